// File: rtl/tape_pkg.sv
// Shared tape-UART constants: clock/baud figures and the UART state encodings.
package tape_pkg;

    localparam int unsigned CLOCK_HZ   = 56842105;
    localparam int unsigned BAUD_RATE  = 115200;
    localparam int unsigned BIT_CYCLES = CLOCK_HZ / BAUD_RATE;
    localparam int unsigned BIT_CNT_W  = $clog2(BIT_CYCLES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_START = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;
    localparam logic [2:0] ST_STOP  = 3'd6;

endpackage

// File: rtl/serial_out_if.sv
// Tape-save FIFO read port: empty flag, read data (non-show-ahead), read strobe.
interface serial_out_if;

    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_req;

    // FIFO side
    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_req
    );

    // Consumer side (the transmitter)
    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_req
    );

endinterface

// File: rtl/serial_out_baud_tick.sv
// Bit-period timer: one-cycle pulse every CYCLES enabled cycles, restartable.
module baud_tick #(
    parameter int unsigned CYCLES = 493
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] r_count;

    // Count 0..CYCLES-1 while enabled, wrap on the bit boundary, zero on restart
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tick = i_enable && (r_count == LAST);

endmodule

// File: rtl/serial_out.sv
// Tape-save UART transmitter, 8N1: tape-out level (normal) or FIFO bytes (turbo).
module serial_out #(
    parameter int unsigned CLOCK_HZ  = tape_pkg::CLOCK_HZ,
    parameter int unsigned BAUD_RATE = tape_pkg::BAUD_RATE
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_save_turbo,
    input  logic             i_tape_out,
    serial_out_if.slave      io_fifo,
    output logic             o_serial_tx,
    output logic             o_busy
);

    import tape_pkg::*;

    localparam int unsigned BIT_CYCLES = CLOCK_HZ / BAUD_RATE;

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_tx;
    logic       r_read_req;
    logic       r_busy;

    logic       w_tick;
    logic       w_bit_active;
    logic       w_frame_go;

    // Timer runs only while the line carries a frame; it is zeroed the cycle
    // before START so the start bit gets a full period.
    assign w_bit_active = (r_state == ST_START) || (r_state == ST_DATA) ||
                          (r_state == ST_STOP);
    assign w_frame_go   = ((r_state == ST_IDLE) && !i_save_turbo) ||
                          (r_state == ST_LOAD);

    baud_tick #(
        .CYCLES (BIT_CYCLES)
    ) u_baud_tick (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_enable  (w_bit_active),
        .i_restart (w_frame_go),
        .o_tick    (w_tick)
    );

    // Frame FSM; line, strobe and busy are registered from the next-state decision
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_read_req <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_read_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!i_save_turbo) begin
                        r_shift <= {8{i_tape_out}};
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (!io_fifo.fifo_empty) begin
                        r_state    <= ST_FETCH;
                        r_read_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_WAIT;
                ST_WAIT:  r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_shift <= io_fifo.fifo_data;
                    r_state <= ST_START;
                    r_tx    <= 1'b0;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_serial_tx           = r_tx;
    assign o_busy                = r_busy;
    assign io_fifo.fifo_read_req = r_read_req;

endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out: frame decode, timing, FIFO handshake, reset.
module tb_serial_out;

    localparam int BIT = 493;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic turbo = 1'b1;
    logic tape_out = 1'b0;
    logic tx;
    logic busy;

    serial_out_if bus ();

    serial_out #(
        .CLOCK_HZ  (56842105),
        .BAUD_RATE (115200)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_save_turbo (turbo),
        .i_tape_out   (tape_out),
        .io_fifo      (bus),
        .o_serial_tx  (tx),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int req_cnt = 0;
    int bad_req = 0;
    logic [7:0] q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: pops on each strobe seen mid-cycle; data valid from then on
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.fifo_read_req === 1'b1) begin
                req_cnt++;
                if (q.size() == 0) bad_req++;
                else bus.fifo_data = q.pop_front();
            end
            bus.fifo_empty = (q.size() == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    // Wait (bounded) for a start bit, then sample all 4930 frame cycles
    task automatic recv_frame(input int bound, output logic [7:0] data, output int t_start);
        int waited;
        int bad;
        logic [9:0] bits;
        waited = 0;
        bad = 0;
        bits = '0;
        data = '0;
        t_start = -1;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) break;
            waited++;
            if (waited >= bound) break;
        end
        if (tx !== 1'b0) begin
            check_eq("start_timeout", {31'b0, tx}, 32'd0);
            return;
        end
        t_start = cyc;
        check_eq("busy_in_frame", {31'b0, busy}, 32'd1);
        for (int b = 0; b < 10; b++) begin
            bits[b] = tx;
            for (int k = 1; k < BIT; k++) begin
                @(negedge clk);
                if (tx !== bits[b]) bad++;
            end
            if (b < 9) @(negedge clk);
        end
        check_eq("start_bit", {31'b0, bits[0]}, 32'd0);
        check_eq("stop_bit", {31'b0, bits[9]}, 32'd1);
        check_eq("bit_len", bad, 0);
        data = bits[8:1];
    endtask

    logic [7:0] d1, d2, d3, d4, d5;
    int t1, t2, t3, t4, t5, k0, r0, hi_bad, busy_bad, w;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_req", {31'b0, bus.fifo_read_req}, 32'd0);
        rst_n = 1'b1;

        // Turbo with empty FIFO: idle high, no strobes
        r0 = req_cnt; hi_bad = 0; busy_bad = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) hi_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check_eq("empty_tx_high", hi_bad, 0);
        check_eq("empty_busy", busy_bad, 0);
        check_eq("empty_no_req", req_cnt - r0, 0);

        // Turbo single byte A5
        r0 = req_cnt;
        push(8'hA5);
        k0 = cyc;
        recv_frame(100, d1, t1);
        check_eq("a5_latency", t1 - k0, 4);
        check_eq("a5_data", {24'b0, d1}, 32'hA5);
        check_eq("a5_reqs", req_cnt - r0, 1);
        @(negedge clk);
        check_eq("a5_idle_busy", {31'b0, busy}, 32'd0);
        check_eq("a5_idle_tx", {31'b0, tx}, 32'd1);

        // Turbo two bytes back to back, then empty
        r0 = req_cnt;
        push(8'h00);
        push(8'hFF);
        k0 = cyc;
        recv_frame(100, d1, t1);
        recv_frame(100, d2, t2);
        check_eq("bb_latency", t1 - k0, 4);
        check_eq("bb_data0", {24'b0, d1}, 32'h00);
        check_eq("bb_data1", {24'b0, d2}, 32'hFF);
        check_eq("bb_period", t2 - t1, 4934);
        hi_bad = 0; busy_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) hi_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check_eq("bb_reqs", req_cnt - r0, 2);
        check_eq("bb_idle_tx", hi_bad, 0);
        check_eq("bb_idle_busy", busy_bad, 0);

        // Normal mode, tape_out 1 then 0 mid second frame
        turbo = 1'b0;
        tape_out = 1'b1;
        k0 = cyc;
        r0 = req_cnt;
        recv_frame(10, d1, t1);
        check_eq("nm_latency", t1 - k0, 1);
        fork
            begin
                while (cyc < t1 + 7000) @(negedge clk);
                tape_out = 1'b0;
            end
            begin
                recv_frame(10, d2, t2);
                recv_frame(10, d3, t3);
            end
        join
        check_eq("nm_data1", {24'b0, d1}, 32'hFF);
        check_eq("nm_data2", {24'b0, d2}, 32'hFF);
        check_eq("nm_data3", {24'b0, d3}, 32'h00);
        check_eq("nm_period2", t2 - t1, 4931);
        check_eq("nm_period3", t3 - t2, 4931);
        check_eq("nm_no_req", req_cnt - r0, 0);

        // Switch to turbo mid-frame: current frame intact, fetch in next IDLE
        fork
            begin
                repeat (2000) @(negedge clk);
                turbo = 1'b1;
                push(8'h3C);
            end
            recv_frame(10, d4, t4);
        join
        check_eq("sw_data4", {24'b0, d4}, 32'h00);
        check_eq("sw_period4", t4 - t3, 4931);
        check_eq("sw_no_req_mid", req_cnt - r0, 0);
        recv_frame(10, d5, t5);
        check_eq("sw_data5", {24'b0, d5}, 32'h3C);
        check_eq("sw_period5", t5 - t4, 4934);
        check_eq("sw_reqs", req_cnt - r0, 1);

        // Reset during DATA bit 3
        @(negedge clk);
        push(8'h00);
        w = 0;
        while (tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq("rs_start", {31'b0, tx}, 32'd0);
        k0 = cyc;
        while (cyc < k0 + 4 * BIT + 200) @(negedge clk);
        check_eq("rs_bit3_low", {31'b0, tx}, 32'd0);
        r0 = req_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rs_tx_async", {31'b0, tx}, 32'd1);
        check_eq("rs_busy_async", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi_bad = 0; busy_bad = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) hi_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check_eq("rs_idle_tx", hi_bad, 0);
        check_eq("rs_idle_busy", busy_bad, 0);
        check_eq("rs_no_req", req_cnt - r0, 0);
        check_eq("req_never_empty", bad_req, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
